// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_addsub_unit.sv
// Combinational (WIDTH+1)-bit adder/subtractor shared by the ITER steps and
// the FIX remainder restore.
module div_addsub_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_divider_32bit.sv
// Multi-cycle non-restoring divider: quotient -> ZLow, remainder -> ZHigh.
// Build option: define DIV_SIGNED_EN for two's-complement signed operands.
module seq_divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_t state, state_nxt;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_res, r_res;
  logic             dbz_res;

  logic             launch, zero_div;
  logic [WIDTH:0]   as_a, as_b, as_sum;
  logic             as_sub;
  logic [WIDTH:0]   acc_fix;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_fin, r_fin;

  // A start coinciding with the done pulse is dropped, not queued.
  assign launch   = (state == IDLE) && start && !done;
  assign zero_div = (divisor == '0);
  assign busy     = (state == ITER) || (state == FIX);

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = zero_div ? DONE : ITER;
      ITER: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One adder serves both phases: ITER works on the shifted {A,Q}, FIX restores A.
  always_comb begin
    as_a   = {acc[WIDTH-1:0], q[WIDTH-1]};
    as_b   = {1'b0, m};
    as_sub = ~acc[WIDTH];
    if (state == FIX) begin
      as_a   = acc;
      as_sub = 1'b0;
    end
  end

  div_addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  assign acc_fix = acc[WIDTH] ? as_sum : acc;

`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
  assign q_fin   = q_neg ? (~q + ONE) : q;
  assign r_fin   = r_neg ? (~acc_fix[WIDTH-1:0] + ONE) : acc_fix[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (!clear) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (launch && !zero_div) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = q;
  assign r_fin   = acc_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      q_res       <= '0;
      r_res       <= '0;
      dbz_res     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          if (zero_div) begin
            q_res   <= {WIDTH{DIV_ZERO_QUOTIENT[0]}};
            r_res   <= dividend;
            dbz_res <= 1'b1;
          end else begin
            acc     <= '0;
            q       <= dvd_mag;
            m       <= dvs_mag;
            cnt     <= CNT_W'(WIDTH - 1);
            dbz_res <= 1'b0;
          end
        end
        ITER: begin
          acc <= as_sum;
          q   <= {q[WIDTH-2:0], ~as_sum[WIDTH]};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          q_res <= q_fin;
          r_res <= r_fin;
        end
        // Visible results only move here, so they hold steady between dones.
        DONE: begin
          done        <= 1'b1;
          quotient    <= q_res;
          remainder   <= r_res;
          div_by_zero <= dbz_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Scoreboard bench for seq_divider_32bit; expectations follow DIV_SIGNED_EN.
module tb_seq_divider_32bit;

  logic        clock = 1'b0;
  logic        clear, start, busy, done, div_by_zero;
  logic [31:0] dividend, divisor, quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_total = 0;

  seq_divider_32bit dut (
    .clock(clock), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (busy) busy_total <= busy_total + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expectation.
  always @(negedge clock) begin
    if (clear === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat);
    exp_t e;
    launch(a, b);
    e.q = eq; e.r = er; e.dbz = edbz; e.t0 = cyc; e.lat = elat;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int b0;
    int n;
    clear = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    clear = 1'b1;

    b0 = busy_total;
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    drain();
    check("busy_cycles", 32'(busy_total - b0), 32'd33);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34); drain();
    run_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 34);      drain();
    run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34); drain();
`else
    run_div(32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 34);        drain();
    run_div(32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 1'b0, 34);           drain();
    run_div(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34); drain();
`endif
    run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 34); drain();

    run_div(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);                drain();
    run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);                      drain();
    run_div(32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);  drain();
    run_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);                      drain();
    run_div(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 34);                      drain();

    // Start during ITER must not disturb the running divide.
    run_div(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 34);
    repeat (4) @(negedge clock);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clock);

    // Start in the done cycle is dropped.
    run_div(32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 34);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    dividend = 32'd7; divisor = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_at_done_ignored", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);

    // Reset during ITER cycle 10 aborts without a done.
    launch(32'd1234, 32'd5);
    repeat (9) @(negedge clock);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    clear = 1'b0;
    @(negedge clock);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    clear = 1'b1;
    repeat (40) @(negedge clock);
    run_div(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
    drain();

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider_32bit.md
Name: seq_divider_32bit

Overview:
- Multi-cycle signed divider that produces the 64-bit result captured by the Z register pair: quotient goes to ZLow, remainder goes to ZHigh.
- Implements non-restoring division, one add/subtract step per clock.
- Each step drives a (WIDTH+1)-bit add/sub unit and consumes its sum.
- Sits between the operand registers (Y, bus) and the Z capture registers; the ALU control FSM launches it for the DIV instruction.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous active-low reset, sampled on the clock edge.
- start  in  1  launch request; honoured only in IDLE.
- dividend  in  WIDTH  numerator, sampled on the start edge.
- divisor  in  WIDTH  denominator, sampled on the start edge.
- busy  out  1  high from the edge after start until the done edge.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  to ZLow; held until the next done.
- remainder  out  WIDTH  to ZHigh; held until the next done.
- div_by_zero  out  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset (clear=0 at an edge): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0.
- Reset mid-operation aborts the divide immediately; no done is issued.
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1, divisor!=0:
  - Latch |dividend| into Q and |divisor| into M.
  - Latch the signs; set A=0 (WIDTH+1 bits), count=WIDTH-1.
  - Go to ITER.
- IDLE, start=1, divisor=0: go to DONE.
  - Results: quotient=all-ones, remainder=dividend, div_by_zero=1.
- ITER, each cycle: shift {A,Q} left by 1.
  - If A was non-negative before the shift: A=A-M; otherwise A=A+M.
  - Q[0]=~A_new[WIDTH].
  - count decrements; after the count=0 cycle, go to FIX.
- FIX, one cycle:
  - If A is negative, A=A+M.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder takes the sign of the dividend.
  - Negate each result in two's complement where required.
  - Register quotient/remainder; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
- Latency:
  - Normal case: start edge = edge 0; done is visible after edge 34 (32 ITER + FIX + DONE).
  - Divide-by-zero case: done is visible after edge 1.
- busy=1 in ITER and FIX only.
- start while busy or in DONE is ignored, with no queuing; start in the same cycle as done is ignored too.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 (wraps), remainder=0, div_by_zero=0.
- Dividend 0 with a nonzero divisor gives quotient=0, remainder=0 (full latency).
- Results and div_by_zero change only on a done edge or on reset.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: two's-complement signed division as described in Behaviour.
- Undefined:
  - Operands are treated as unsigned; no magnitude or negation logic.
  - FIX performs only the remainder restore.
  - Overflow case does not apply: 0x80000000 / 0xFFFFFFFF gives quotient=0, remainder=0x80000000.
  - Latency is identical.

Decomposition:
- Shared package (div_pkg):
  - State enum div_state_t {IDLE, ITER, FIX, DONE}.
  - DIV_WIDTH=32.
  - DIV_ZERO_QUOTIENT=32'hFFFFFFFF.
  - Iteration counter width localparam = $clog2(WIDTH).
- One sub-module: div_addsub_unit, a combinational (WIDTH+1)-bit add/subtract.
  - Inputs: a, b, sub. Output: sum.
  - Instantiated once; shared by ITER and the FIX restore.
  - Sign negation uses separate incrementers.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 34 edges after start; busy high for 33 cycles.
- (DIV_SIGNED_EN) -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- 5 / 0 -> done after 1 edge, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; a following 9 / 3 returns 3, 0 and clears div_by_zero.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0 (signed build); quotient=0, remainder=0x80000000 (unsigned build).
- start asserted at ITER cycle 5 with different operands -> ignored; the original result is returned at the expected edge.
- clear=0 during ITER cycle 10 -> next edge busy=0, outputs=0, no done pulse; then 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF (unsigned) or 0xFFFFFFFF, remainder 0 (signed).
